// File: rtl/add32_sequencer_pkg.sv
// add32_sequencer shared definitions.
// FSM encoding and datapath widths for the sequencer and its bus.
package add32_sequencer_pkg;

  localparam int HALF_W = 16;
  localparam int FULL_W = 2 * HALF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/add32_sequencer_if.sv
// add32_sequencer bus: two requesters, shared 16-bit adder, one response.
// master is the environment side, slave is the sequencer.
interface add32_sequencer_if;
  import add32_sequencer_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [FULL_W-1:0] req0_a;
  logic [FULL_W-1:0] req0_b;
  logic              req0_sub;

  logic              req1_valid;
  logic              req1_ready;
  logic [FULL_W-1:0] req1_a;
  logic [FULL_W-1:0] req1_b;
  logic              req1_sub;

  logic [HALF_W-1:0] add_a;
  logic [HALF_W-1:0] add_b;
  logic              add_cin;
  logic [HALF_W-1:0] add_s;
  logic              add_cout;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [FULL_W-1:0] resp_sum;
  logic              resp_cout;
  logic              resp_ovf;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    input  add_a, add_b, add_cin,
    output add_s, add_cout,
    input  resp_valid, resp_id, resp_sum,
    input  resp_cout, resp_ovf,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    output add_a, add_b, add_cin,
    input  add_s, add_cout,
    output resp_valid, resp_id, resp_sum,
    output resp_cout, resp_ovf,
    input  resp_ready
  );

endinterface

// File: rtl/add32_sequencer_arb.sv
// rr_arb2: two-way arbiter, round-robin or fixed priority.
// last names the requester granted most recently.
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = (RR_EN && !last) ? 2'b10 : 2'b01;
    end else if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/add32_sequencer.sv
// add32_sequencer: 32-bit add/sub built from two passes
// through a shared external 16-bit adder.
module add32_sequencer
  import add32_sequencer_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  add32_sequencer_if.slave bus
);

  state_t            state;
  logic              last;
  logic              id;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic [FULL_W-1:0] a_in;
  logic [FULL_W-1:0] b_in;
  logic [FULL_W-1:0] b_eff;
  logic              sub_in;
  logic [HALF_W-1:0] a_hi;
  logic [HALF_W-1:0] b_hi;
  logic [HALF_W-1:0] sum_lo;
  logic              ovf;

  rr_arb2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .valid({bus.req1_valid, bus.req0_valid}),
    .last (last),
    .grant(grant)
  );

  assign accept = (state == IDLE) && !reset
                  && (grant != 2'b00);
  assign bus.req0_ready = accept && grant[0];
  assign bus.req1_ready = accept && grant[1];

  assign sel    = grant[1];
  assign a_in   = sel ? bus.req1_a   : bus.req0_a;
  assign b_in   = sel ? bus.req1_b   : bus.req0_b;
  assign sub_in = sel ? bus.req1_sub : bus.req0_sub;
  assign b_eff  = sub_in ? ~b_in : b_in;

  // Signed overflow from the high half's sign bits.
  assign ovf = (a_hi[HALF_W-1] == b_hi[HALF_W-1])
               && (bus.add_s[HALF_W-1] != a_hi[HALF_W-1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      last           <= 1'b1;
      id             <= 1'b0;
      a_hi           <= '0;
      b_hi           <= '0;
      sum_lo         <= '0;
      bus.add_a      <= '0;
      bus.add_b      <= '0;
      bus.add_cin    <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= 1'b0;
      bus.resp_sum   <= '0;
      bus.resp_cout  <= 1'b0;
      bus.resp_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state       <= LO;
            last        <= sel;
            id          <= sel;
            a_hi        <= a_in[FULL_W-1:HALF_W];
            b_hi        <= b_eff[FULL_W-1:HALF_W];
            bus.add_a   <= a_in[HALF_W-1:0];
            bus.add_b   <= b_eff[HALF_W-1:0];
            bus.add_cin <= sub_in;
          end
        end
        LO: begin
          state       <= HI;
          sum_lo      <= bus.add_s;
          bus.add_a   <= a_hi;
          bus.add_b   <= b_hi;
          bus.add_cin <= bus.add_cout;
        end
        HI: begin
          state          <= DONE;
          bus.resp_valid <= 1'b1;
          bus.resp_id    <= id;
          bus.resp_sum   <= {bus.add_s, sum_lo};
          bus.resp_cout  <= bus.add_cout;
          bus.resp_ovf   <= ovf;
          bus.add_a      <= '0;
          bus.add_b      <= '0;
          bus.add_cin    <= 1'b0;
        end
        DONE: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
